// File: rtl/control_modulo_if.sv
// Control/status bus between the modulo controller (master) and the modulo datapath (slave).
interface control_modulo_if;
  logic       valid_i;
  logic [2:0] alu_mode_o;
  logic       wren_update_Zahlen_o;
  logic       wren_Zahl1_to_erg_o;
  logic       wren_term_erg_o;
  logic       wren_res_to_erg_o;
  logic       erg_to_alu_a_o;
  logic       Zahl2_to_alu_b_o;
  logic       check_for_termination_o;

  modport master (
    input  valid_i,
    output alu_mode_o, wren_update_Zahlen_o, wren_Zahl1_to_erg_o, wren_term_erg_o,
           wren_res_to_erg_o, erg_to_alu_a_o, Zahl2_to_alu_b_o, check_for_termination_o
  );
  modport slave (
    output valid_i,
    input  alu_mode_o, wren_update_Zahlen_o, wren_Zahl1_to_erg_o, wren_term_erg_o,
           wren_res_to_erg_o, erg_to_alu_a_o, Zahl2_to_alu_b_o, check_for_termination_o
  );
endinterface

// File: rtl/control_modulo.sv
// Sequencer for Zahl1 mod Zahl2 by repeated compare/subtract on the modulo datapath.
// Optional CONTROL_MODULO_ITER_CNT_EN adds iter_cnt_o (SUB passes of the last completed run).
module control_modulo #(
  parameter int unsigned ALU_LAT  = 1,
  parameter logic [15:0] MAX_ITER = 16'hFFFF,
  parameter logic [2:0]  ALU_SUB  = 3'd1,
  parameter logic [2:0]  ALU_LT   = 3'd2
) (
  input  logic clk,
  input  logic rst_i,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  output logic error_o,
`ifdef CONTROL_MODULO_ITER_CNT_EN
  output logic [15:0] iter_cnt_o,
`endif
  control_modulo_if.master dp
);

  localparam int unsigned E    = ALU_LAT + 2;
  localparam logic [7:0]  LAST = 8'(E - 1);

  typedef enum logic [2:0] {IDLE, LOAD, INIT, CMP, CHECK, SUB, DONE, ERR} state_e;

  state_e      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [15:0] iter_q, iter_d;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= IDLE;
      phase_q <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d                    = state_q;
    phase_d                    = '0;
    iter_d                     = iter_q;
    busy_o                     = 1'b1;
    done_o                     = 1'b0;
    error_o                    = 1'b0;
    dp.alu_mode_o              = 3'd0;
    dp.wren_update_Zahlen_o    = 1'b0;
    dp.wren_Zahl1_to_erg_o     = 1'b0;
    dp.wren_term_erg_o         = 1'b0;
    dp.wren_res_to_erg_o       = 1'b0;
    dp.erg_to_alu_a_o          = 1'b0;
    dp.Zahl2_to_alu_b_o        = 1'b0;
    dp.check_for_termination_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          state_d = LOAD;
          iter_d  = '0;
        end
      end
      LOAD: begin
        // first cycle lets the datapath input register capture the operands
        if (phase_q == 8'd1) begin
          dp.wren_update_Zahlen_o = 1'b1;
          state_d                 = INIT;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      INIT: begin
        dp.wren_Zahl1_to_erg_o = 1'b1;
        state_d                = CMP;
      end
      CMP, SUB: begin
        dp.erg_to_alu_a_o   = 1'b1;
        dp.Zahl2_to_alu_b_o = 1'b1;
        dp.alu_mode_o       = (state_q == CMP) ? ALU_LT : ALU_SUB;
        if (phase_q == LAST) begin
          if (state_q == CMP) begin
            dp.wren_term_erg_o = 1'b1;
            state_d            = CHECK;
          end else begin
            dp.wren_res_to_erg_o = 1'b1;
            state_d              = CMP;
            iter_d               = (iter_q == 16'hFFFF) ? iter_q : iter_q + 16'd1;
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      CHECK: begin
        dp.check_for_termination_o = 1'b1;
        if (dp.valid_i)              state_d = DONE;
        else if (iter_q == MAX_ITER) state_d = ERR;
        else                         state_d = SUB;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        done_o  = 1'b1;
        error_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CONTROL_MODULO_ITER_CNT_EN
  logic [15:0] iter_cnt_q;

  always_ff @(posedge clk) begin
    if (rst_i)
      iter_cnt_q <= '0;
    else if (state_q == CHECK && state_d != SUB)
      iter_cnt_q <= iter_q;
  end

  assign iter_cnt_o = iter_cnt_q;
`endif

endmodule

// File: doc/control_modulo.md
Name: control_modulo

Overview:
- FSM controller that sequences the modulo datapath to compute Zahl1 mod Zahl2 by repeated compare/subtract.
- Drives the datapath's write-back flags, register-transfer selects, ALU mode and termination check, and reads back valid_o.
- Gives the top level a start/busy/done handshake and an iteration-limit error exit.

Parameters:
- ALU_LAT, 1, ALU pipeline latency in cycles from operand select to ALU result; the result is registered once more inside the datapath.
- MAX_ITER, 16'hFFFF, maximum number of SUB passes before error abort.
- ALU_SUB, 3'd1, ALU mode code for a-b.
- ALU_LT, 3'd2, ALU mode code for (a<b) ? 1 : 0.

Ports:
- clk  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  request; sampled only in IDLE
- valid_i  in  1  datapath valid_o (termination flag gated by check)
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle completion pulse
- error_o  out  1  one-cycle pulse, coincident with done_o, on iteration-limit abort
- alu_mode_o  out  3  ALU mode
- wren_update_Zahlen_o  out  1  latch operands
- wren_Zahl1_to_erg_o  out  1  ergebnis <- Zahl1
- wren_term_erg_o  out  1  termination register <- ALU result
- wren_res_to_erg_o  out  1  ergebnis <- ALU result
- erg_to_alu_a_o  out  1  ALU a <- ergebnis
- Zahl2_to_alu_b_o  out  1  ALU b <- Zahl2
- check_for_termination_o  out  1  enable termination evaluation

Behaviour:
- Reset: state=IDLE, iteration counter=0, all outputs 0. Reset in any state aborts the operation the same way; no done_o is issued.
- All outputs are registered or decoded from state only; none depend combinationally on start_i.
- Let E = ALU_LAT+2, the execute length: operand select, ALU latency, then the result register.
- State sequence and outputs:
- IDLE: start_i=1 -> LOAD; clear the iteration counter.
- LOAD: 2 cycles, to cover the datapath input register. wren_update_Zahlen_o=1 in the 2nd cycle only. Then go to INIT.
- INIT: 1 cycle, wren_Zahl1_to_erg_o=1. Then go to CMP.
- CMP: E cycles. erg_to_alu_a_o=1, Zahl2_to_alu_b_o=1 and alu_mode_o=ALU_LT are held for all E cycles. wren_term_erg_o=1 in the last cycle only. Then go to CHECK.
- CHECK: 1 cycle, check_for_termination_o=1.
  - valid_i=1 -> DONE.
  - Otherwise, if counter==MAX_ITER -> ERR.
  - Otherwise -> SUB.
- SUB: E cycles. Same selects as CMP, with alu_mode_o=ALU_SUB. wren_res_to_erg_o=1 in the last cycle only. The counter increments on exit. Then go to CMP.
- DONE: done_o=1 for 1 cycle, then IDLE.
- ERR: done_o=1 and error_o=1 for 1 cycle, then IDLE. The ergebnis content is undefined.
- alu_mode_o=0 and all selects are 0 outside CMP/SUB.
- At most one wren_* output is high in any cycle.
- start_i while busy_o=1 is ignored and not queued. start_i held high at DONE->IDLE begins a new run one cycle later.
- Latency for k subtractions: done_o is high in cycle 4 + (k+1)(E+1) + kE after the start_i sampling edge.
- The counter is 16 bits and saturates, never wraps.
- Zahl2=0 never terminates and always exits via ERR after MAX_ITER SUB passes.

Optional Feature:
- Macro: CONTROL_MODULO_ITER_CNT_EN.
- When defined: adds output iter_cnt_o [15:0], equal to the number of SUB passes in the last completed run.
  - Updated on entry to DONE/ERR and held until the next DONE/ERR.
  - Reset value 0.
- When undefined: the port is absent and the behaviour is otherwise identical.

Test Plan:
- ALU_LAT=1, Zahl1=17, Zahl2=5, start pulse -> 3 SUB passes, done_o in cycle 29, ergebnis=2, error_o=0, busy_o high cycles 1..29.
- Zahl1=3, Zahl2=7 -> no SUB, done_o in cycle 8, ergebnis=3.
- Zahl1=20, Zahl2=5 -> 4 SUB passes, ergebnis=0, done_o in cycle 36.
- MAX_ITER=4, Zahl2=0 -> error_o and done_o together in one cycle after exactly 4 SUB passes, then IDLE.
- rst_i=1 during the 2nd SUB pass -> next cycle IDLE, all outputs 0, no done_o. A fresh start with 17/5 then gives ergebnis=2.
- start_i held high during busy, and pulses mid-run -> runs are not restarted. With CONTROL_MODULO_ITER_CNT_EN defined, iter_cnt_o=3 after the 17/5 run.
